// File: rtl/adc_spi_pkg.sv
// Shared constants and state encoding for the ADC128S022 SPI responder.
package adc_spi_pkg;

  localparam int ADC_DATA_W         = 12;
  localparam int ADC_CH_W           = 3;
  localparam int ADC_FRAME_BITS     = 16;
  localparam int ADC_LEAD_ZEROS     = 4;
  localparam int ADC_ADDR_FIRST_BIT = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } adc_state_e;

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronizer with a third registered copy for rise/fall detection.
module spi_in_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/adc128s022_spi_slave.sv
// ADC128S022-style SPI responder: address decode on rises, sample out on falls,
// backed by a writable 2**CH_W entry sample bank.
module adc128s022_spi_slave
  import adc_spi_pkg::*;
#(
  parameter int DATA_W     = ADC_DATA_W,
  parameter int CH_W       = ADC_CH_W,
  parameter int FRAME_BITS = ADC_FRAME_BITS,
  parameter int LEAD_ZEROS = ADC_LEAD_ZEROS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SCLK,
  input  logic              CS_N,
  input  logic              DIN,
  output logic              DOUT,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic [CH_W-1:0]   frame_ch,
  output logic [CH_W-1:0]   next_ch
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] ADDR_LO   = CNT_W'(ADC_ADDR_FIRST_BIT);
  localparam logic [CNT_W-1:0] ADDR_HI   = CNT_W'(ADC_ADDR_FIRST_BIT + CH_W - 1);
  localparam logic [CNT_W-1:0] LEAD      = CNT_W'(LEAD_ZEROS);
  localparam logic [CNT_W-1:0] LAST_POS  = CNT_W'(FRAME_BITS - 1);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic din_s, din_rise_unused, din_fall_unused;

  spi_in_sync #(.RST_VAL(1'b1)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(SCLK),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_in_sync #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .d(CS_N),
    .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
  );
  spi_in_sync #(.RST_VAL(1'b1)) u_din (
    .clk(clk), .rst_n(rst_n), .d(DIN),
    .level(din_s), .rise(din_rise_unused), .fall(din_fall_unused)
  );

  adc_state_e        state;
  logic [CNT_W-1:0]  rise_cnt, fall_cnt, rise_next, bit_pos;
  logic [DATA_W-1:0] shift_sr;
  logic [DATA_W-1:0] bank [2**CH_W];
  logic [CH_W-1:0]   cur_ch, addr_sr;

  assign rise_next = rise_cnt + 1'b1;
  assign bit_pos   = LAST_POS - fall_cnt;

  // Bank writes use NBA, so a snapshot in the same cycle sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**CH_W; i++) bank[i] <= '0;
    end else if (wr_en) begin
      bank[wr_ch] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      DOUT       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_ch   <= '0;
      next_ch    <= '0;
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      shift_sr   <= '0;
      cur_ch     <= '0;
      addr_sr    <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          DOUT <= 1'b0;
          if (cs_fall) begin
            shift_sr <= bank[next_ch];
            cur_ch   <= next_ch;
            rise_cnt <= '0;
            fall_cnt <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            if (rise_cnt == FULL) begin
              frame_done <= 1'b1;
              frame_ch   <= cur_ch;
              next_ch    <= addr_sr;
            end else begin
              frame_err <= 1'b1;
            end
            DOUT  <= 1'b0;
            state <= IDLE;
          end else begin
            if (sclk_rise) begin
              if (rise_cnt != FULL) rise_cnt <= rise_next;
              if (rise_next >= ADDR_LO && rise_next <= ADDR_HI)
                addr_sr <= {addr_sr[CH_W-2:0], din_s};
            end
            // fall_cnt is the 0-based index of the fall being handled.
            if (sclk_fall) begin
              if (fall_cnt >= LEAD && fall_cnt < FULL)
                DOUT <= shift_sr[bit_pos[IDX_W-1:0]];
              else
                DOUT <= 1'b0;
              if (fall_cnt != FULL) fall_cnt <= fall_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
